// File: rtl/sam_pkg.sv
// Shared definitions for the SAM command sequencer: seqOp bit positions, command
// encoding, per-group compare result type and sequencer state encoding.
package sam_pkg;

    localparam int unsigned OP_CFG_BIT  = 0;
    localparam int unsigned OP_SCAN_BIT = 1;
    localparam int unsigned OP_SET_TYPE = 2;
    localparam int unsigned OP_INX_TYPE = 3;

    typedef enum logic [1:0] {
        CmdCfg      = 2'd0,
        CmdScanItem = 2'd1,
        CmdScanPage = 2'd2,
        CmdRsvd     = 2'd3
    } cmd_op_e;

    typedef struct packed {
        logic eq;
        logic gtr;
    } compare_t;

    typedef enum logic [2:0] {
        StIdle,
        StSet,
        StReq,
        StCfg,
        StScan,
        StSettle,
        StResp
    } seq_state_e;

endpackage

// File: rtl/sam_sequencer_if.sv
// Command, DRAM, cell-broadcast and response signals of the SAM sequencer.
// slave = sequencer side, master = the block driving commands/results into it.
interface sam_sequencer_if #(
    parameter int unsigned CELL_SIZE     = 8,
    parameter int unsigned NUM_GROUPS    = 4,
    parameter int unsigned OP_SHORT_BITS = 8
) ();
    logic                      cmdValid;
    logic                      cmdReady;
    logic [1:0]                cmdOp;
    logic [CELL_SIZE-1:0]      cmdTarget;
    logic                      dramReq;
    logic                      dramValid;
    logic [OP_SHORT_BITS-1:0]  seqOp;
    logic [CELL_SIZE-1:0]      target;
    logic [2*NUM_GROUPS-1:0]   rsltI;
    logic                      rsltValid;
    logic                      rsltReady;
    logic [2*NUM_GROUPS-1:0]   rsltData;
    logic                      rsltErr;
    logic [15:0]               clkCount;

    modport slave (
        input  cmdValid, cmdOp, cmdTarget, dramValid, rsltI, rsltReady,
        output cmdReady, dramReq, seqOp, target, rsltValid, rsltData, rsltErr, clkCount
    );

    modport master (
        output cmdValid, cmdOp, cmdTarget, dramValid, rsltI, rsltReady,
        input  cmdReady, dramReq, seqOp, target, rsltValid, rsltData, rsltErr, clkCount
    );
endinterface

// File: rtl/sam_seq_timeout.sv
// DRAM wait watchdog for the SAM sequencer (built only with SAM_SEQ_TIMEOUT_EN).
// Counter is held at zero outside REQ, so it restarts on every REQ entry.
module sam_seq_timeout #(
    parameter int unsigned DramTimeout = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    output logic timeout_o
);
    logic [7:0] count_q, count_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    always_comb begin
        count_d   = req_i ? count_q + 8'd1 : 8'd0;
        timeout_o = req_i && (count_q == 8'(DramTimeout - 1));
    end
endmodule

// File: rtl/sam_sequencer.sv
// SAM command sequencer: drives seqOp/target to the cell array and returns group results.
// Optional DRAM timeout enabled by defining SAM_SEQ_TIMEOUT_EN.
module sam_sequencer
    import sam_pkg::*;
#(
    parameter int unsigned CELL_SIZE     = 8,
    parameter int unsigned NUM_GROUPS    = 4,
    parameter int unsigned OP_SHORT_BITS = 8
`ifdef SAM_SEQ_TIMEOUT_EN
    , parameter int unsigned DRAM_TIMEOUT = 255
`endif
) (
    input logic            clk,
    input logic            reset,
    sam_sequencer_if.slave bus
);
    seq_state_e                 state_q, state_d;
    logic                       is_scan_q, is_scan_d;
    logic                       is_item_q, is_item_d;
    logic [CELL_SIZE-1:0]       target_q, target_d;
    compare_t [NUM_GROUPS-1:0]  rslt_data_q, rslt_data_d;
    logic [15:0]                clk_count_q, clk_count_d;
    logic                       err_q, err_d;
    logic                       dram_timeout;
    cmd_op_e                    cmd_op;

    logic [OP_SHORT_BITS-1:0]   seq_op;
    logic                       cmd_ready, dram_req, rslt_valid;

    assign cmd_op = cmd_op_e'(bus.cmdOp);

`ifdef SAM_SEQ_TIMEOUT_EN
    sam_seq_timeout #(
        .DramTimeout (DRAM_TIMEOUT)
    ) u_timeout (
        .clk_i     (clk),
        .rst_i     (reset),
        .req_i     (state_q == StReq),
        .timeout_o (dram_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    always_comb begin
        err_d = err_q;
        if (state_q == StReq && !bus.dramValid && dram_timeout) err_d = 1'b1;
        if (state_q == StResp && bus.rsltReady)                 err_d = 1'b0;
    end
`else
    assign dram_timeout = 1'b0;
    assign err_q        = 1'b0;
    assign err_d        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmdValid) begin
                    state_d = (cmd_op inside {CmdScanItem, CmdScanPage}) ? StSet : StReq;
                end
            end
            StSet:    state_d = StReq;
            // dramValid takes priority over a timeout landing in the same cycle
            StReq: begin
                if (bus.dramValid)   state_d = is_scan_q ? StScan : StCfg;
                else if (dram_timeout) state_d = StResp;
            end
            StCfg:    state_d = StResp;
            StScan:   state_d = StSettle;
            StSettle: state_d = StResp;
            StResp:   if (bus.rsltReady) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        seq_op     = '0;
        cmd_ready  = 1'b0;
        dram_req   = 1'b0;
        rslt_valid = 1'b0;
        unique case (state_q)
            StIdle: cmd_ready = 1'b1;
            StSet: begin
                seq_op[OP_SET_TYPE] = 1'b1;
                seq_op[OP_INX_TYPE] = is_item_q;
            end
            StReq:   dram_req              = 1'b1;
            StCfg:   seq_op[OP_CFG_BIT]    = 1'b1;
            StScan:  seq_op[OP_SCAN_BIT]   = 1'b1;
            StResp:  rslt_valid            = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_scan_q   <= 1'b0;
            is_item_q   <= 1'b0;
            target_q    <= '0;
            rslt_data_q <= '0;
            clk_count_q <= '0;
        end else begin
            is_scan_q   <= is_scan_d;
            is_item_q   <= is_item_d;
            target_q    <= target_d;
            rslt_data_q <= rslt_data_d;
            clk_count_q <= clk_count_d;
        end
    end

    always_comb begin
        is_scan_d   = is_scan_q;
        is_item_d   = is_item_q;
        target_d    = target_q;
        rslt_data_d = rslt_data_q;
        clk_count_d = clk_count_q + 16'd1;
        if (state_q == StIdle && bus.cmdValid) begin
            is_scan_d = cmd_op inside {CmdScanItem, CmdScanPage};
            is_item_d = (cmd_op == CmdScanItem);
            target_d  = bus.cmdTarget;
        end
        if (state_q == StCfg)    rslt_data_d = '0;
        if (state_q == StSettle) rslt_data_d = bus.rsltI;
        if (state_q == StReq && !bus.dramValid && dram_timeout) rslt_data_d = '0;
    end

    assign bus.cmdReady  = cmd_ready;
    assign bus.dramReq   = dram_req;
    assign bus.seqOp     = seq_op;
    assign bus.target    = target_q;
    assign bus.rsltValid = rslt_valid;
    assign bus.rsltData  = rslt_data_q;
    assign bus.rsltErr   = err_q;
    assign bus.clkCount  = clk_count_q;
endmodule

// File: tb/tb_sam_sequencer.sv
// Randomized bench for sam_sequencer: per-transaction cycle schedule model.
// Define SAM_SEQ_TIMEOUT_EN to also exercise the DRAM timeout (DRAM_TIMEOUT=4).
module tb_sam_sequencer;
    localparam int unsigned CS = 8;
    localparam int unsigned NG = 4;
    localparam int unsigned OB = 8;
`ifdef SAM_SEQ_TIMEOUT_EN
    localparam int TO   = 4;
    localparam int KMAX = TO - 1;
`else
    localparam int KMAX = 4;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edges = 0;

    always #5 clk = ~clk;

    sam_sequencer_if #(.CELL_SIZE(CS), .NUM_GROUPS(NG), .OP_SHORT_BITS(OB)) bus ();

`ifdef SAM_SEQ_TIMEOUT_EN
    sam_sequencer #(
        .CELL_SIZE(CS), .NUM_GROUPS(NG), .OP_SHORT_BITS(OB), .DRAM_TIMEOUT(TO)
    ) dut (.clk(clk), .reset(reset), .bus(bus));
`else
    sam_sequencer #(
        .CELL_SIZE(CS), .NUM_GROUPS(NG), .OP_SHORT_BITS(OB)
    ) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    // Rising edges seen since reset released; clkCount must equal this mod 2^16.
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("clkCount", 32'(bus.clkCount), 32'(edges % 65536));
    endtask

    task automatic idle_inputs();
        bus.cmdValid  = 1'b0;
        bus.cmdOp     = 2'($urandom_range(0, 3));
        bus.cmdTarget = 8'($urandom_range(0, 255));
        bus.dramValid = 1'($urandom_range(0, 1));
        bus.rsltI     = 8'($urandom_range(0, 255));
        bus.rsltReady = 1'($urandom_range(0, 1));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cmdReady"}, 32'(bus.cmdReady), 32'd1);
        check({tag, "_rsltValid"}, 32'(bus.rsltValid), 32'd0);
        check({tag, "_dramReq"}, 32'(bus.dramReq), 32'd0);
        check({tag, "_seqOp"}, 32'(bus.seqOp), 32'd0);
        check({tag, "_rsltErr"}, 32'(bus.rsltErr), 32'd0);
    endtask

    // Called in an idle cycle. k: REQ cycles before dramValid; h: RESP cycles with rsltReady low.
    // to: never answer REQ and expect the timeout response.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] tgt, input int k,
                           input logic [7:0] rslt, input int h, input bit to);
        bit         scan;
        bit         item;
        int         req_lo, req_hi, resp_start, resp_end;
        logic [7:0] exp_data;
        logic [7:0] eop;
        scan     = (op == 2'd1) || (op == 2'd2);
        item     = (op == 2'd1);
        req_lo   = scan ? 1 : 0;
        req_hi   = req_lo + k;
        exp_data = (scan && !to) ? rslt : 8'h00;
        if (to)        resp_start = req_hi + 1;
        else if (scan) resp_start = req_hi + 3;
        else           resp_start = req_hi + 2;
        resp_end = resp_start + h;

        check("accept_cmdReady", 32'(bus.cmdReady), 32'd1);
        idle_inputs();
        bus.cmdValid  = 1'b1;
        bus.cmdOp     = op;
        bus.cmdTarget = tgt;
        tick();
        for (int i = 0; i <= resp_end; i++) begin
            eop = 8'h00;
            if (scan && i == 0)         eop = item ? 8'h0C : 8'h04;
            if (!to && i == req_hi + 1) eop = scan ? 8'h02 : 8'h01;
            check("seqOp", 32'(bus.seqOp), 32'(eop));
            check("dramReq", 32'(bus.dramReq), 32'(i >= req_lo && i <= req_hi));
            check("cmdReady_busy", 32'(bus.cmdReady), 32'd0);
            check("target", 32'(bus.target), 32'(tgt));
            check("rsltValid", 32'(bus.rsltValid), 32'(i >= resp_start));
            if (i >= resp_start) begin
                check("rsltData", 32'(bus.rsltData), 32'(exp_data));
                check("rsltErr", 32'(bus.rsltErr), 32'(to));
            end
            bus.cmdValid  = 1'($urandom_range(0, 1));
            bus.cmdOp     = 2'($urandom_range(0, 3));
            bus.cmdTarget = 8'($urandom_range(0, 255));
            bus.rsltI     = (scan && !to && i == req_hi + 2) ? rslt : 8'($urandom_range(0, 255));
            if (i >= req_lo && i <= req_hi) bus.dramValid = !to && (i == req_hi);
            else                            bus.dramValid = 1'($urandom_range(0, 1));
            if (i >= resp_start) bus.rsltReady = (i == resp_end);
            else                 bus.rsltReady = 1'($urandom_range(0, 1));
            tick();
        end
        check_idle("post");
        bus.cmdValid = 1'b0;
    endtask

    initial begin
        bus.cmdValid  = 1'b0;
        bus.cmdOp     = 2'd0;
        bus.cmdTarget = 8'd0;
        bus.dramValid = 1'b0;
        bus.rsltI     = 8'd0;
        bus.rsltReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst");
        check("rst_target", 32'(bus.target), 32'd0);
        check("rst_rsltData", 32'(bus.rsltData), 32'd0);
        check("rst_clkCount", 32'(bus.clkCount), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_idle("start");

        // Directed cases
        run_cmd(2'd0, 8'h33, 2, 8'hFF, 1, 1'b0);
        run_cmd(2'd1, 8'h5A, 0, 8'h1B, 0, 1'b0);
        run_cmd(2'd2, 8'hC3, 1, 8'hE7, 10, 1'b0);
        run_cmd(2'd3, 8'h81, 0, 8'h77, 0, 1'b0);

        // Asynchronous reset while waiting in REQ
        idle_inputs();
        bus.cmdValid  = 1'b1;
        bus.cmdOp     = 2'd2;
        bus.cmdTarget = 8'h99;
        tick();
        bus.cmdValid  = 1'b0;
        bus.dramValid = 1'b0;
        tick();
        check("abort_dramReq_before", 32'(bus.dramReq), 32'd1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("abort_dramReq", 32'(bus.dramReq), 32'd0);
        check("abort_seqOp", 32'(bus.seqOp), 32'd0);
        check("abort_rsltValid", 32'(bus.rsltValid), 32'd0);
        check("abort_target", 32'(bus.target), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            tick();
            check_idle("after_abort");
        end
        run_cmd(2'd0, 8'h12, 1, 8'h00, 0, 1'b0);

        // Randomized transactions with random idle gaps
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                idle_inputs();
                tick();
                check_idle("gap");
            end
            run_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                    $urandom_range(0, KMAX), 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(0, 3), 1'b0);
        end

`ifdef SAM_SEQ_TIMEOUT_EN
        run_cmd(2'd1, 8'h44, TO - 1, 8'h00, 2, 1'b1);
        run_cmd(2'd0, 8'h45, TO - 1, 8'h00, 0, 1'b1);
        run_cmd(2'd2, 8'h46, TO - 1, 8'h5C, 0, 1'b0);
`endif

        // Free-running counter wrap
        idle_inputs();
        while (edges < 65535) tick();
        check("wrap_hi", 32'(bus.clkCount), 32'h0000FFFF);
        tick();
        check("wrap_lo", 32'(bus.clkCount), 32'h00000000);
        tick();
        check_idle("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
